uart_rx_cfg: RTL and testbench

UART_RX_CFG -- requirements
Module: uart_rx_cfg

---
 rtl/uart_rx_cfg.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_rx_cfg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg -- configurable oversampling UART receiver with receive storage.
//
// The rx line is resynchronised, sampled OVERSAMPLE times per bit and each
// bit is decided by a 2-of-3 majority around the bit centre. Good frames are
// pushed into storage. Frames with framing or parity errors are dropped and
// the matching one-cycle error pulse is raised. An all-zero frame with a bad
// stop bit is a line break: the receiver waits for the line to go high again.
//
// Build option: define UART_RX_FIFO_EN to get a FIFO_DEPTH-entry circular
// FIFO. Without it a single holding register is used and FIFO_DEPTH is ignored.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   rd_en      pops the head entry when valid is high
//   data_out   head entry, LSB = first bit received
//   valid      storage non-empty
//   rx_busy    receiver not idle
//   frame_err  one-cycle pulse: stop bit read 0 (including a break)
//   parity_err one-cycle pulse: parity bit mismatch
//   overrun    one-cycle pulse: good frame dropped because storage was full
module uart_rx_cfg #(
  parameter int CLK_FREQ   = 1_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam int HALF    = OVERSAMPLE / 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SMP_W-1:0] T_VOTE0  = SMP_W'(HALF - 1);
  localparam logic [SMP_W-1:0] T_VOTE1  = SMP_W'(HALF);
  localparam logic [SMP_W-1:0] T_DEC    = SMP_W'(HALF + 1);
  localparam logic [SMP_W-1:0] T_END    = SMP_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("uart_rx_cfg: illegal parameter set");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  logic rx_meta, rx_sync, rx_last;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_last <= rx_sync;
    end
  end

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [SMP_W-1:0]     smp_cnt;
  logic [1:0]           vote;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad, stop_bad, stop_idx;
  logic                 push_req;
  logic [DATA_BITS-1:0] push_data;

  logic tick, at_dec, at_end, majority, exp_par, last_stop, stop_fail;
  assign tick      = (div_cnt == DIV_LAST);
  assign at_dec    = tick && (smp_cnt == T_DEC);
  assign at_end    = tick && (smp_cnt == T_END);
  // Third vote is the live sample taken at the decision tick.
  assign majority  = (vote[0] & vote[1]) | (vote[0] & rx_sync) | (vote[1] & rx_sync);
  assign exp_par   = (PARITY == 1) ? ~(^shift_reg) : ^shift_reg;
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign stop_fail = stop_bad | ~majority;
  assign rx_busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      smp_cnt    <= '0;
      vote       <= 2'b11;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      stop_bad   <= 1'b0;
      stop_idx   <= 1'b0;
      push_req   <= 1'b0;
      push_data  <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      push_req   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      if (state != S_IDLE && state != S_BREAK) begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) smp_cnt <= (smp_cnt == T_END) ? '0 : smp_cnt + 1'b1;
        if (tick && smp_cnt == T_VOTE0) vote[0] <= rx_sync;
        if (tick && smp_cnt == T_VOTE1) vote[1] <= rx_sync;
      end
      case (state)
        S_IDLE: begin
          // Bit timing is anchored to the detected start edge.
          if (rx_last && !rx_sync) begin
            state   <= S_START;
            div_cnt <= '0;
            smp_cnt <= '0;
          end
        end
        S_START: begin
          if (at_dec && majority) begin
            state <= S_IDLE;            // glitch: start bit did not hold
          end else if (at_end) begin
            state   <= S_DATA;
            bit_idx <= '0;
          end
        end
        S_DATA: begin
          if (at_dec) shift_reg <= {majority, shift_reg[DATA_BITS-1:1]};
          if (at_end) begin
            if (bit_idx == BIT_LAST) begin
              state    <= (PARITY == 0) ? S_STOP : S_PARITY;
              par_bad  <= 1'b0;
              stop_bad <= 1'b0;
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (at_dec) par_bad <= (majority != exp_par);
          if (at_end) state <= S_STOP;
        end
        S_STOP: begin
          if (at_dec) begin
            if (last_stop) begin
              // Leave mid-bit so the next start edge is not missed.
              if (stop_fail && shift_reg == '0) begin
                frame_err <= 1'b1;
                state     <= S_BREAK;
              end else begin
                state <= S_IDLE;
                if (stop_fail) begin
                  frame_err <= 1'b1;
                end else if (par_bad) begin
                  parity_err <= 1'b1;
                end else begin
                  push_req  <= 1'b1;
                  push_data <= shift_reg;
                end
              end
            end else begin
              stop_bad <= stop_fail;
            end
          end else if (at_end) begin
            stop_idx <= 1'b1;
          end
        end
        S_BREAK: begin
          if (rx_sync) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [PTR_W:0]       count;
  logic                 pop, full, do_push;

  assign valid   = (count != '0);
  assign full    = (count == CNT_FULL);
  assign pop     = rd_en && valid;
  // A pop in the same cycle frees the slot a full store needs.
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
      overrun  <= 1'b0;
    end else begin
      overrun <= push_req && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      // data_out holds the head; it only moves when the head changes.
      if (do_push && count == '0) begin
        data_out <= push_data;
      end else if (pop) begin
        if (count > (PTR_W + 1)'(1)) data_out <= mem[rd_ptr + 1'b1];
        else if (do_push)            data_out <= push_data;
      end
    end
  end
`else
  logic hold_valid, pop, do_push;

  assign valid   = hold_valid;
  assign pop     = rd_en && hold_valid;
  assign do_push = push_req && (!hold_valid || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      data_out   <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push_req && hold_valid && !pop;
      if (do_push) begin
        data_out   <= push_data;
        hold_valid <= 1'b1;
      end else if (pop) begin
        hold_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed testbench for uart_rx_cfg at DIV=1 (one sample tick per clock).
// dut_a: 8N1 receiver on line rx_a. dut_p: 8E1 receiver on line rx_p.
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 16;
`ifdef UART_RX_FIFO_EN
  localparam int STORE_N = 4;
`else
  localparam int STORE_N = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_p = 1'b1, rd_a = 1'b0, rd_p = 1'b0;
  logic [7:0] dout_a, dout_p;
  logic valid_a, busy_a, fe_a, pe_a, ov_a;
  logic valid_p, busy_p, fe_p, pe_p, ov_p;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLK_FREQ(1_843_200), .BAUD_RATE(115200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rd_en(rd_a), .data_out(dout_a),
    .valid(valid_a), .rx_busy(busy_a), .frame_err(fe_a), .parity_err(pe_a),
    .overrun(ov_a)
  );

  uart_rx_cfg #(
    .CLK_FREQ(1_843_200), .BAUD_RATE(115200), .OVERSAMPLE(16),
    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .rx(rx_p), .rd_en(rd_p), .data_out(dout_p),
    .valid(valid_p), .rx_busy(busy_p), .frame_err(fe_p), .parity_err(pe_p),
    .overrun(ov_p)
  );

  int tests = 0;
  int fails = 0;
  int fe_cnt_a = 0, pe_cnt_a = 0, ov_cnt_a = 0, busy_cnt_a = 0;
  int fe_cnt_p = 0, pe_cnt_p = 0;

  // Pulse counters sampled on the inactive edge.
  always @(negedge clk) begin
    if (fe_a)   fe_cnt_a++;
    if (pe_a)   pe_cnt_a++;
    if (ov_a)   ov_cnt_a++;
    if (busy_a) busy_cnt_a++;
    if (fe_p)   fe_cnt_p++;
    if (pe_p)   pe_cnt_p++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int line, input logic b);
    if (line == 0) rx_a = b;
    else           rx_p = b;
  endtask

  task automatic send_frame(input int line, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop);
    set_rx(line, 1'b0);
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      set_rx(line, d[i]);
      wait_clks(BIT_CLKS);
    end
    if (has_par) begin
      set_rx(line, par);
      wait_clks(BIT_CLKS);
    end
    set_rx(line, stop);
    wait_clks(BIT_CLKS);
    set_rx(line, 1'b1);
  endtask

  task automatic wait_valid(input int line, input int budget);
    int n = 0;
    while (((line == 0) ? valid_a : valid_p) !== 1'b1 && n < budget) begin
      wait_clks(1);
      n++;
    end
    check("valid_rise", (line == 0) ? valid_a : valid_p, 1);
  endtask

  task automatic pop(input int line);
    if (line == 0) rd_a = 1'b1;
    else           rd_p = 1'b1;
    wait_clks(1);
    rd_a = 1'b0;
    rd_p = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, pe0, ov0, b0, n;
    logic [7:0] d;

    // Reset state
    wait_clks(3);
    check("rst_dout_a", dout_a, 0);
    check("rst_valid_a", valid_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_flags_a", {fe_a, pe_a, ov_a}, 0);
    check("rst_dout_p", dout_p, 0);
    check("rst_valid_p", valid_p, 0);
    rst_n = 1'b1;
    wait_clks(4);

    // 8N1 byte 0xA5
    send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 40);
    check("a5_data", dout_a, 8'hA5);
    check("a5_flags", {fe_cnt_a[7:0], pe_cnt_a[7:0], ov_cnt_a[7:0]}, 0);
    pop(0);
    check("a5_pop_empty", valid_a, 0);

    // Even parity: 0x07 has three ones, so parity bit 0 is wrong, 1 is right
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
    wait_clks(4);
    check("par_bad_pulses", pe_cnt_p, 1);
    check("par_bad_valid", valid_p, 0);
    check("par_bad_no_fe", fe_cnt_p, 0);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    wait_valid(1, 40);
    check("par_ok_data", dout_p, 8'h07);
    check("par_ok_no_pe", pe_cnt_p, 1);
    pop(1);

    // Glitch: 4 clocks low while idle
    fe0 = fe_cnt_a; pe0 = pe_cnt_a; b0 = busy_cnt_a;
    set_rx(0, 1'b0);
    wait_clks(4);
    set_rx(0, 1'b1);
    n = 0;
    while (n < 10) begin
      wait_clks(1);
      n++;
      if (busy_a == 1'b0) break;
    end
    check("glitch_idle", busy_a, 0);
    check("glitch_seen", busy_cnt_a > b0, 1);
    wait_clks(20);
    check("glitch_no_push", valid_a, 0);
    check("glitch_no_flags", (fe_cnt_a - fe0) + (pe_cnt_a - pe0), 0);

    // Overrun: five bytes, no reads
    ov0 = ov_cnt_a;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      send_frame(0, d, 1'b0, 1'b0, 1'b1);
      wait_clks(4);
      if (i == 4) check("ovr_after_4", ov_cnt_a - ov0, 4 - STORE_N);
    end
    check("ovr_after_5", ov_cnt_a - ov0, 5 - STORE_N);
    for (int i = 1; i <= STORE_N; i++) begin
      check("ovr_rd_valid", valid_a, 1);
      check("ovr_rd_data", dout_a, i);
      pop(0);
    end
    check("ovr_drained", valid_a, 0);

    // Break: 20 bit times low
    fe0 = fe_cnt_a;
    set_rx(0, 1'b0);
    wait_clks(20 * BIT_CLKS);
    check("brk_busy", busy_a, 1);
    set_rx(0, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("brk_fe_once", fe_cnt_a - fe0, 1);
    check("brk_no_push", valid_a, 0);
    check("brk_idle", busy_a, 0);
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 40);
    check("brk_next_data", dout_a, 8'h3C);
    check("brk_next_no_fe", fe_cnt_a - fe0, 1);
    pop(0);

    // Reset in the middle of data bit 3 of 0x5A
    d = 8'h5A;
    set_rx(0, 1'b0);
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      set_rx(0, d[i]);
      wait_clks(BIT_CLKS);
    end
    set_rx(0, d[3]);
    wait_clks(BIT_CLKS / 2);
    rst_n = 1'b0;
    wait_clks(2);
    check("mid_rst_dout", dout_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_flags", {fe_a, pe_a, ov_a}, 0);
    set_rx(0, 1'b1);
    wait_clks(2);
    fe0 = fe_cnt_a; pe0 = pe_cnt_a;
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("post_rst_idle", busy_a, 0);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    wait_valid(0, 40);
    check("post_rst_data", dout_a, 8'h5A);
    check("post_rst_no_flags", (fe_cnt_a - fe0) + (pe_cnt_a - pe0), 0);
    pop(0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
